// File: rtl/fpu_int_packer.sv
// Converts a signed 32-bit integer to the packed {sign, exp[5:0], frac[24:0]} float format.
// Normalisation shifts the magnitude left one bit per clock until the leading one reaches bit 31.
module fpu_int_packer #(
  parameter int BIAS = 31
) (
  input  logic               clock100KHz,
  input  logic               reset,
  input  logic signed [31:0] int_in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [31:0]        data_out,
  output logic [3:0]         status_out,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  localparam logic [3:0] ST_EXACT   = 4'b0001;
  localparam logic [3:0] ST_INEXACT = 4'b0010;

  state_t      state, state_nxt;
  logic        sign_q;
  logic [31:0] mag_q;
  logic [4:0]  k_q;

  // Two's-complement magnitude; the most negative value maps to 0x80000000 as unsigned.
  function automatic logic [31:0] abs32(input logic signed [31:0] v);
    logic [31:0] u;
    u = v;
    return v[31] ? (~u + 32'd1) : u;
  endfunction

  function automatic logic [5:0] exp_of(input logic [4:0] k);
    logic [6:0] e;
    e = 7'(BIAS) + 7'd31 - {2'b00, k};
    return e[5:0];
  endfunction

  // Truncation toward zero: discarded low bits only flag INEXACT, never round.
  function automatic logic [31:0] pack_trunc(input logic s, input logic [4:0] k,
                                              input logic [24:0] frac);
    return {s, exp_of(k), frac};
  endfunction

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = NORM;
      end
      NORM: begin
        busy = 1'b1;
        if (mag_q == 32'd0 || mag_q[31]) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      state      <= IDLE;
      sign_q     <= 1'b0;
      mag_q      <= 32'd0;
      k_q        <= 5'd0;
      data_out   <= 32'd0;
      status_out <= 4'b0000;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q <= int_in[31];
            mag_q  <= abs32(int_in);
            k_q    <= 5'd0;
          end
        end
        NORM: begin
          if (mag_q == 32'd0) begin
            data_out   <= 32'd0;
            status_out <= ST_EXACT;
          end else if (mag_q[31]) begin
            data_out   <= pack_trunc(sign_q, k_q, mag_q[30:6]);
            status_out <= (mag_q[5:0] != 6'd0) ? ST_INEXACT : ST_EXACT;
          end else begin
            mag_q <= mag_q << 1;
            k_q   <= k_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_int_packer.sv
// Self-checking bench for fpu_int_packer: directed vectors, back-pressure, mid-flight reset, random.
`timescale 1ns/1ps
module tb_fpu_int_packer;

  localparam int BIAS = 31;

  logic               clock100KHz = 1'b0;
  logic               reset;
  logic signed [31:0] int_in;
  logic               in_valid;
  logic               in_ready;
  logic               out_ready;
  logic               out_valid;
  logic [31:0]        data_out;
  logic [3:0]         status_out;
  logic               busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  fpu_int_packer #(.BIAS(BIAS)) dut (
    .clock100KHz(clock100KHz),
    .reset(reset),
    .int_in(int_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .data_out(data_out),
    .status_out(status_out),
    .busy(busy)
  );

  always #5 clock100KHz = ~clock100KHz;

  // Reference: value = 2^idx * (1 + frac/2^25); frac and exactness come from integer division.
  function automatic void ref_model(input logic [31:0] v, output logic [31:0] d,
                                    output logic [3:0] s, output int lat);
    longint m, rem, frac, p;
    int idx, k;
    m = longint'({32'b0, v});
    if (v[31]) m = 64'h1_0000_0000 - m;
    if (m == 0) begin
      d = 32'd0; s = 4'b0001; lat = 1;
      return;
    end
    idx = 0;
    while ((64'd1 << (idx + 1)) <= m) idx++;
    k    = 31 - idx;
    p    = 64'd1 << idx;
    rem  = (m - p) * (64'd1 << 25);
    frac = rem / p;
    d    = {v[31], 6'(BIAS + 31 - k), 25'(frac)};
    s    = (rem % p != 0) ? 4'b0010 : 4'b0001;
    lat  = k + 1;
  endfunction

  // Accepts one operand, measures latency, checks result, then completes the output handshake.
  task automatic do_conv(input string name, input logic [31:0] v, input logic [31:0] exp_d,
                         input logic [3:0] exp_s, input int exp_lat, input int stall);
    int lat;
    bit busy_ok;
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL %s in_ready_before_accept: got %b want 1", name, in_ready);
    else pass_cnt++;
    int_in = v; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clock100KHz); #1;
    in_valid = 1'b0; int_in = $urandom();
    lat = 0; busy_ok = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) busy_ok = 0;
      @(posedge clock100KHz); #1;
      lat++;
    end
    chk_cnt++;
    if (lat !== exp_lat) $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    else pass_cnt++;
    chk_cnt++;
    if (!busy_ok) $display("FAIL %s busy_during_norm: got 0 want 1", name);
    else pass_cnt++;
    chk_cnt++;
    if (data_out !== exp_d) $display("FAIL %s data_out: got %h want %h", name, data_out, exp_d);
    else pass_cnt++;
    chk_cnt++;
    if (status_out !== exp_s) $display("FAIL %s status_out: got %b want %b", name, status_out, exp_s);
    else pass_cnt++;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      @(posedge clock100KHz); #1;
      chk_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || data_out !== exp_d ||
          status_out !== exp_s)
        $display("FAIL %s stall_hold[%0d]: got v=%b r=%b d=%h s=%b want v=1 r=0 d=%h s=%b",
                 name, i, out_valid, in_ready, data_out, status_out, exp_d, exp_s);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock100KHz); #1;
    out_ready = 1'b0;
    chk_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || data_out !== exp_d ||
        status_out !== exp_s)
      $display("FAIL %s after_handshake: got v=%b r=%b b=%b d=%h s=%b want v=0 r=1 b=0 d=%h s=%b",
               name, out_valid, in_ready, busy, data_out, status_out, exp_d, exp_s);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; int_in = 32'h1234_5678;
    repeat (2) @(posedge clock100KHz);
    #1 reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || data_out !== 32'd0 ||
        status_out !== 4'b0000)
      $display("FAIL reset_state: got r=%b v=%b b=%b d=%h s=%b want r=1 v=0 b=0 d=0 s=0000",
               in_ready, out_valid, busy, data_out, status_out);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [31:0] vin  [4] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFA, 32'h7FFF_FFFF};
    logic [31:0] vout [4] = '{32'h0000_0000, 32'h3E00_0000, 32'hC300_0000, 32'h7BFF_FFFF};
    logic [3:0]  vst  [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
    int          vlat [4] = '{1, 32, 30, 2};
    for (int i = 0; i < 4; i++) do_conv($sformatf("directed%0d", i), vin[i], vout[i], vst[i], vlat[i], 0);
  endtask

  task automatic test_backpressure();
    do_conv("min_int_stall", 32'h8000_0000, 32'hFC00_0000, 4'b0001, 1, 10);
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d; logic [3:0] s; int lat;
    int_in = 32'd1; in_valid = 1'b1;
    @(posedge clock100KHz); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clock100KHz);
    #1 reset = 1'b1; out_ready = 1'b1;
    @(posedge clock100KHz); #1;
    reset = 1'b0; out_ready = 1'b0;
    chk_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || data_out !== 32'd0 ||
        status_out !== 4'b0000)
      $display("FAIL midflight_reset: got r=%b v=%b b=%b d=%h s=%b want r=1 v=0 b=0 d=0 s=0000",
               in_ready, out_valid, busy, data_out, status_out);
    else pass_cnt++;
    ref_model(32'd3, d, s, lat);
    do_conv("after_reset_3", 32'd3, d, s, lat, 0);
  endtask

  task automatic test_random();
    logic [31:0] v, d; logic [3:0] s; int lat;
    for (int i = 0; i < 24; i++) begin
      v = $urandom() >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      ref_model(v, d, s, lat);
      do_conv($sformatf("random%0d_%h", i, v), v, d, s, lat, $urandom_range(0, 2));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v, d; logic [3:0] s; int lat;
    for (int i = 0; i < 4; i++) begin
      v = 32'h0000_00FF << (i * 7);
      ref_model(v, d, s, lat);
      do_conv($sformatf("b2b%0d", i), v, d, s, lat, 0);
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; int_in = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
